regfile_wb_queue: RTL
=====================

# regfile_wb_queue

Write-back queue that sits between the execution pipelines and the 2-read/4-write register file. It accepts up to four results per cycle from the producers, buffers them in order, and drains up to four per cycle onto the register file's four write ports. Same-cycle writes to one register are never issued together, so port priority inside the storage flop never matters. It also reports, per read port, whether a queued write is still pending for the addressed register, so issue logic can stall.

## Interface
Parameters:
- OPRAND_WIDTH, 32, data width
- REGNAME_WIDTH, 5, register address width
- DEPTH, 8, queue entries; power of two, ≥4
- ZERO_REG, 1, 1 = writes to register 0 are discarded at enqueue

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low
- enq_valid_i  input  4  per-lane result valid; lane 0 oldest
- enq_addr_i  input  4×REGNAME_WIDTH  per-lane destination
- enq_data_i  input  4×OPRAND_WIDTH  per-lane result
- enq_ready_o  output  1  queue accepts a full 4-lane group this cycle
- wb_stall_i  input  1  block draining this cycle
- write11/12/21/22_en_o  output  1 each  write-port enables (drain slots 0..3)
- write11/12/21/22_addr_o  output  REGNAME_WIDTH each
- write11/12/21/22_data_o  output  OPRAND_WIDTH each
- read1_en_i, read2_en_i  input  1 each  read-port probe enable
- read1_addr_i, read2_addr_i  input  REGNAME_WIDTH each
- read1_pend_o, read2_pend_o  output  1 each  queued write pending for that address
- count_o  output  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: circular buffer of DEPTH {addr, data} entries; head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy count register.
- enq_ready_o = (DEPTH − count) ≥ 4, from the registered count. Acceptance is all-or-nothing per cycle.
- Enqueue when enq_ready_o: valid lanes are compacted in lane order (0→3) and written at tail, tail += accepted. With ZERO_REG=1, lanes with addr 0 are treated as invalid. Valid lanes while enq_ready_o=0 are ignored; the producer holds them.
- Drain when !wb_stall_i: candidate slots k = 0..3 map to entries head+k, with k < count. Slot k is issued only if slot k−1 issued and its addr differs from every earlier issued slot this cycle. The first collision stops draining, so order is preserved. head += issued, count updates by +accepted − issued in the same edge.
- Write outputs are combinational from the head entries. Non-issued slots drive en=0, addr=0, data=0.
- readN_pend_o = readN_en_i && some occupied entry has addr == readN_addr_i, including entries draining this cycle. It is combinational and never asserts for addr 0 when ZERO_REG=1.

## Timing
- Enqueue-to-write latency: ≥1 cycle. A result accepted at edge N can appear on a write port in cycle N+1, then commits at edge N+1.
- Pend clears the cycle after the last matching entry drains.
- Simultaneous enqueue and drain in one cycle are legal. A full queue that drains does not raise enq_ready_o until the next cycle.
- wb_stall_i with count=0 has no effect. Enqueue continues during stall.
- Reset (any time, mid-drain included): head=tail=count=0, all write enables 0, addr/data outputs 0, pend outputs 0, enq_ready_o=1 while rst low and after release. Contents need no reset.

## Structure
- Package wb_pkg: wb_entry_t struct {addr, data}, lane count constant WB_LANES=4.
- Sub-module wb_drain_sel: combinational; takes the 4 head entries plus count and stall; outputs the issued-slot mask and the issued count. It holds the collision chain.
- Top holds the pointers, count, storage, compaction and pend comparators.

## Test plan
- Reset, then lanes 0–3 valid with addrs 1,2,3,4 and data 0xA..0xD → next cycle all four enables high with addrs 1–4; count returns to 0.
- Enqueue addrs 5,5,6,7 → cycle 1 issues only slot 0 (addr 5); cycle 2 issues 5,6,7 in order; the final value of reg 5 is the lane-1 data.
- Hold wb_stall_i and enqueue two full groups (count=8) → enq_ready_o=0 and a third group is dropped; release stall → 4 drained, then enq_ready_o=1 next cycle.
- Lanes valid with addr 0 (ZERO_REG=1) alongside addr 9 → only addr 9 is queued; count=1.
- Queue addr 12, probe read1_addr_i=12 with en=1 → read1_pend_o=1 until the cycle after the addr-12 write issues; read2 probe on addr 13 → 0.
- Assert rst mid-drain with count=6 → outputs zero immediately; after release count=0 and a fresh group drains normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
// Lane/drain-slot count is fixed at four to match the register file's four write ports.
package wb_pkg;

  localparam int WB_LANES   = 4;
  localparam int WB_ADDR_W  = 5;
  localparam int WB_DATA_W  = 32;
  localparam int WB_SLOT_CW = $clog2(WB_LANES + 1);

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_drain_sel.sv
// Picks which of the four head entries drain this cycle; combinational, zero latency.
// Stops at the first address collision or at count, so issue is always an in-order prefix.
module wb_drain_sel
  import wb_pkg::*;
#(
  parameter int AW = 5,
  parameter int CW = 4
) (
  input  logic [WB_LANES-1:0][AW-1:0] head_addr,
  input  logic [CW-1:0]               count,
  input  logic                        stall,
  output logic [WB_LANES-1:0]         issue,
  output logic [WB_SLOT_CW-1:0]       issue_cnt
);

  logic prev;

  always_comb begin
    issue     = '0;
    issue_cnt = '0;
    prev      = !stall;
    for (int k = 0; k < WB_LANES; k++) begin
      issue[k] = prev && (CW'(k) < count);
      // every earlier slot issued (prefix), so compare against all of them
      for (int j = 0; j < k; j++) begin
        if (head_addr[j] == head_addr[k]) issue[k] = 1'b0;
      end
      prev      = issue[k];
      issue_cnt = issue_cnt + WB_SLOT_CW'(issue[k]);
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue: 4-lane compacting enqueue, up to 4 collision-free drains per cycle.
// Latency >=1 cycle; enqueue is all-or-nothing, ready only when 4 entries are free.
module regfile_wb_queue
  import wb_pkg::*;
#(
  parameter int OPRAND_WIDTH  = 32,
  parameter int REGNAME_WIDTH = 5,
  parameter int DEPTH         = 8,
  parameter int ZERO_REG      = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [WB_LANES-1:0]                         enq_valid_i,
  input  logic [WB_LANES-1:0][REGNAME_WIDTH-1:0]      enq_addr_i,
  input  logic [WB_LANES-1:0][OPRAND_WIDTH-1:0]       enq_data_i,
  output logic                                        enq_ready_o,
  input  logic                                        wb_stall_i,
  output logic                                        write11_en_o,
  output logic                                        write12_en_o,
  output logic                                        write21_en_o,
  output logic                                        write22_en_o,
  output logic [REGNAME_WIDTH-1:0]                    write11_addr_o,
  output logic [REGNAME_WIDTH-1:0]                    write12_addr_o,
  output logic [REGNAME_WIDTH-1:0]                    write21_addr_o,
  output logic [REGNAME_WIDTH-1:0]                    write22_addr_o,
  output logic [OPRAND_WIDTH-1:0]                     write11_data_o,
  output logic [OPRAND_WIDTH-1:0]                     write12_data_o,
  output logic [OPRAND_WIDTH-1:0]                     write21_data_o,
  output logic [OPRAND_WIDTH-1:0]                     write22_data_o,
  input  logic                                        read1_en_i,
  input  logic                                        read2_en_i,
  input  logic [REGNAME_WIDTH-1:0]                    read1_addr_i,
  input  logic [REGNAME_WIDTH-1:0]                    read2_addr_i,
  output logic                                        read1_pend_o,
  output logic                                        read2_pend_o,
  output logic [$clog2(DEPTH):0]                      count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [REGNAME_WIDTH-1:0] addr;
    logic [OPRAND_WIDTH-1:0]  data;
  } entry_t;

  entry_t                               mem [DEPTH];
  logic [PW-1:0]                        head;
  logic [PW-1:0]                        tail;
  logic [CW-1:0]                        count;

  logic [WB_LANES-1:0]                  lane_ok;
  logic [WB_LANES-1:0][1:0]             lane_off;
  logic [WB_SLOT_CW-1:0]                lane_cnt;
  logic [WB_SLOT_CW-1:0]                acc_cnt;

  entry_t [WB_LANES-1:0]                head_ent;
  logic [WB_LANES-1:0][REGNAME_WIDTH-1:0] head_addr;
  logic [WB_LANES-1:0]                  issue;
  logic [WB_SLOT_CW-1:0]                iss_cnt;
  logic [WB_LANES-1:0][REGNAME_WIDTH-1:0] wr_addr;
  logic [WB_LANES-1:0][OPRAND_WIDTH-1:0]  wr_data;

  logic [DEPTH-1:0]                     occ;
  logic                                 hit1;
  logic                                 hit2;

  assign count_o     = count;
  assign enq_ready_o = (count <= CW'(DEPTH - WB_LANES));
  assign acc_cnt     = enq_ready_o ? lane_cnt : '0;

  // Compaction: each surviving lane lands at tail + (number of surviving lanes before it).
  always_comb begin
    lane_ok  = '0;
    lane_off = '0;
    lane_cnt = '0;
    for (int l = 0; l < WB_LANES; l++) begin
      lane_ok[l]  = enq_valid_i[l] && !((ZERO_REG != 0) && (enq_addr_i[l] == '0));
      lane_off[l] = lane_cnt[1:0];
      lane_cnt    = lane_cnt + WB_SLOT_CW'(lane_ok[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ready_o) begin
      for (int l = 0; l < WB_LANES; l++) begin
        if (lane_ok[l]) begin
          mem[tail + PW'(lane_off[l])] <= '{addr: enq_addr_i[l], data: enq_data_i[l]};
        end
      end
    end
  end

  always_comb begin
    head_ent  = '0;
    head_addr = '0;
    for (int k = 0; k < WB_LANES; k++) begin
      head_ent[k]  = mem[head + PW'(k)];
      head_addr[k] = head_ent[k].addr;
    end
  end

  wb_drain_sel #(
    .AW (REGNAME_WIDTH),
    .CW (CW)
  ) u_drain_sel (
    .head_addr (head_addr),
    .count     (count),
    .stall     (wb_stall_i),
    .issue     (issue),
    .issue_cnt (iss_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(acc_cnt);
      head  <= head + PW'(iss_cnt);
      count <= count + CW'(acc_cnt) - CW'(iss_cnt);
    end
  end

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int k = 0; k < WB_LANES; k++) begin
      if (issue[k]) begin
        wr_addr[k] = head_ent[k].addr;
        wr_data[k] = head_ent[k].data;
      end
    end
  end

  assign write11_en_o   = issue[0];
  assign write12_en_o   = issue[1];
  assign write21_en_o   = issue[2];
  assign write22_en_o   = issue[3];
  assign write11_addr_o = wr_addr[0];
  assign write12_addr_o = wr_addr[1];
  assign write21_addr_o = wr_addr[2];
  assign write22_addr_o = wr_addr[3];
  assign write11_data_o = wr_data[0];
  assign write12_data_o = wr_data[1];
  assign write21_data_o = wr_data[2];
  assign write22_data_o = wr_data[3];

  // Entries draining this cycle are still occupied, so pend holds until the edge that retires them.
  always_comb begin
    occ  = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = ({1'b0, PW'(i) - head} < count);
      if (occ[i] && (mem[i].addr == read1_addr_i)) hit1 = 1'b1;
      if (occ[i] && (mem[i].addr == read2_addr_i)) hit2 = 1'b1;
    end
  end

  assign read1_pend_o = read1_en_i && hit1 && !((ZERO_REG != 0) && (read1_addr_i == '0));
  assign read2_pend_o = read2_en_i && hit2 && !((ZERO_REG != 0) && (read2_addr_i == '0));

endmodule
